// File: rtl/data_memory_responder.sv
// LC3 data-memory responder: one request at a time, serviced from a word array after WAIT_CYCLES.
// Optional DATA_MEMORY_RESP_ERR_EN adds resp_err and rejects addresses outside the array.
module data_memory_responder #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2,
  parameter     INIT_FILE   = ""
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              data_req,
  input  logic              data_rd,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_din,
  output logic [DATA_W-1:0] data_dout,
  output logic              complete_data,
  output logic              busy,
`ifdef DATA_MEMORY_RESP_ERR_EN
  output logic              resp_err,
`endif
  output logic [1:0]        state_dbg
);

  // Handshake: data_req is taken only while busy=0; the transaction ends with a
  // one-cycle complete_data pulse, and busy stays high from acceptance until then.

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [3:0] WAIT_LD = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              rd_q;
  logic [IDX_W-1:0]  idx_q;
  logic [DATA_W-1:0] din_q;
  logic              oor_q;
  logic              req_oor;
  logic              accept;
  logic              resp_entry;
  logic              rd_sel;
  logic [IDX_W-1:0]  idx_sel;
  logic              oor_sel;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] mem [DEPTH];

`ifdef DATA_MEMORY_RESP_ERR_EN
  assign req_oor = |data_addr[ADDR_W-1:IDX_W];
`else
  // Upper address bits alias onto the array.
  logic unused_hi;
  assign unused_hi = ^data_addr[ADDR_W-1:IDX_W];
  assign req_oor   = 1'b0;
`endif

  assign accept = (state_q == S_IDLE) && data_req;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (data_req) begin
          cnt_d   = WAIT_LD;
          state_d = (WAIT_LD == 4'd0) ? S_RESP : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // With WAIT_CYCLES==0 the read happens on the accepting edge, so use the live request.
  assign resp_entry = (state_d == S_RESP) && (state_q != S_RESP);
  assign rd_sel     = (state_q == S_IDLE) ? data_rd : rd_q;
  assign idx_sel    = (state_q == S_IDLE) ? data_addr[IDX_W-1:0] : idx_q;
  assign oor_sel    = (state_q == S_IDLE) ? req_oor : oor_q;
  assign rd_data    = oor_sel ? DATA_W'(16'hDEAD) : mem[idx_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      rd_q      <= 1'b0;
      idx_q     <= '0;
      din_q     <= '0;
      oor_q     <= 1'b0;
      data_dout <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_q  <= data_rd;
        idx_q <= data_addr[IDX_W-1:0];
        din_q <= data_din;
        oor_q <= req_oor;
      end
      if (resp_entry && rd_sel) data_dout <= rd_data;
    end
  end

  // Storage is deliberately not reset; a reset during WAIT leaves state IDLE so no write lands.
  always_ff @(posedge clock) begin
    if (state_q == S_RESP && !rd_q && !oor_q) mem[idx_q] <= din_q;
  end

  assign complete_data = (state_q == S_RESP);
  assign busy          = (state_q != S_IDLE);
  assign state_dbg     = state_q;
`ifdef DATA_MEMORY_RESP_ERR_EN
  assign resp_err      = complete_data && oor_q;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a vector table on a WAIT_CYCLES=2 instance
// plus hand-written sequences (busy ignore, zero-wait back-to-back, reset mid-transaction).
module tb_data_memory_responder;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0, rd0 = 1'b0, req1 = 1'b0, rd1 = 1'b0;
  logic [15:0] addr0 = '0, din0 = '0, addr1 = '0, din1 = '0;
  logic [15:0] dout0, dout1;
  logic        cmp0, cmp1, busy0, busy1;
  logic [1:0]  st0, st1;
  logic        err0, err1;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  data_memory_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(2)) dut0 (
    .clock(clock), .reset_n(reset_n), .data_req(req0), .data_rd(rd0),
    .data_addr(addr0), .data_din(din0), .data_dout(dout0),
    .complete_data(cmp0), .busy(busy0),
`ifdef DATA_MEMORY_RESP_ERR_EN
    .resp_err(err0),
`endif
    .state_dbg(st0)
  );

  data_memory_responder #(.ADDR_W(16), .DATA_W(16), .DEPTH(1024), .WAIT_CYCLES(0)) dut1 (
    .clock(clock), .reset_n(reset_n), .data_req(req1), .data_rd(rd1),
    .data_addr(addr1), .data_din(din1), .data_dout(dout1),
    .complete_data(cmp1), .busy(busy1),
`ifdef DATA_MEMORY_RESP_ERR_EN
    .resp_err(err1),
`endif
    .state_dbg(st1)
  );

`ifndef DATA_MEMORY_RESP_ERR_EN
  assign err0 = 1'b0;
  assign err1 = 1'b0;
`endif

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] exp_dout;
    logic        exp_err;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic req, input logic rd,
                       input logic [15:0] a, input logic [15:0] d);
    if (sel == 0) begin
      req0 = req; rd0 = rd; addr0 = a; din0 = d;
    end else begin
      req1 = req; rd1 = rd; addr1 = a; din1 = d;
    end
  endtask

  // Issues one request; lat counts sampled cycles from acceptance to complete_data (20 = timeout).
  task automatic txn(input int sel, input logic rd, input logic [15:0] a, input logic [15:0] d,
                     output int lat, output logic [15:0] dout, output logic err,
                     output logic busy_ok);
    logic c, b;
    @(negedge clock);
    drive(sel, 1'b1, rd, a, d);
    @(posedge clock);
    #1 drive(sel, 1'b0, rd, a, d);
    lat = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      lat++;
      c = (sel == 0) ? cmp0 : cmp1;
      b = (sel == 0) ? busy0 : busy1;
      if (b !== 1'b1) busy_ok = 1'b0;
      if (c === 1'b1) break;
    end
    dout = (sel == 0) ? dout0 : dout1;
    err  = (sel == 0) ? err0 : err1;
  endtask

  int          lat, ncomp, first;
  logic [15:0] dv;
  logic        ev, bok;

  initial begin
    vecs[0]  = '{1'b0, 16'h0010, 16'h1234, 16'h0000, 1'b0};
    vecs[1]  = '{1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0};
    vecs[2]  = '{1'b0, 16'h0011, 16'h5678, 16'h1234, 1'b0};
    vecs[3]  = '{1'b1, 16'h0011, 16'h0000, 16'h5678, 1'b0};
    vecs[4]  = '{1'b1, 16'h0010, 16'h0000, 16'h1234, 1'b0};
    vecs[5]  = '{1'b0, 16'h03FF, 16'hFFFF, 16'h1234, 1'b0};
    vecs[6]  = '{1'b1, 16'h03FF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0001, 16'hFFFF, 1'b0};
    vecs[8]  = '{1'b1, 16'h0000, 16'h0000, 16'h0001, 1'b0};
    vecs[9]  = '{1'b0, 16'h0001, 16'h1111, 16'h0001, 1'b0};
`ifdef DATA_MEMORY_RESP_ERR_EN
    vecs[10] = '{1'b0, 16'h0401, 16'hA5A5, 16'h0001, 1'b1};
    vecs[11] = '{1'b1, 16'h0001, 16'h0000, 16'h1111, 1'b0};
    vecs[12] = '{1'b1, 16'h0401, 16'h0000, 16'hDEAD, 1'b1};
    vecs[13] = '{1'b1, 16'hFC10, 16'h0000, 16'hDEAD, 1'b1};
`else
    vecs[10] = '{1'b0, 16'h0401, 16'hA5A5, 16'h0001, 1'b0};
    vecs[11] = '{1'b1, 16'h0001, 16'h0000, 16'hA5A5, 1'b0};
    vecs[12] = '{1'b1, 16'h0401, 16'h0000, 16'hA5A5, 1'b0};
    vecs[13] = '{1'b1, 16'hFC10, 16'h0000, 16'h1234, 1'b0};
`endif

    // Reset held for three cycles.
    repeat (3) @(negedge clock);
    check("rst_dout0", 32'(dout0), 32'h0);
    check("rst_cmp0", 32'(cmp0), 32'h0);
    check("rst_busy0", 32'(busy0), 32'h0);
    check("rst_state0", 32'(st0), 32'h0);
    check("rst_dout1", 32'(dout1), 32'h0);
    check("rst_busy1", 32'(busy1), 32'h0);
    reset_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      txn(0, vecs[i].rd, vecs[i].addr, vecs[i].din, lat, dv, ev, bok);
      check($sformatf("v%0d_lat", i), 32'(lat), 32'd3);
      check($sformatf("v%0d_busy", i), 32'(bok), 32'd1);
      check($sformatf("v%0d_dout", i), 32'(dv), 32'(vecs[i].exp_dout));
`ifdef DATA_MEMORY_RESP_ERR_EN
      check($sformatf("v%0d_err", i), 32'(ev), 32'(vecs[i].exp_err));
`endif
      @(negedge clock);
      check($sformatf("v%0d_pulse", i), 32'(cmp0), 32'h0);
      check($sformatf("v%0d_idle", i), 32'(busy0), 32'h0);
    end

    // Second request in the cycle after the first must be ignored.
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 16'h0020, 16'hCAFE);
    @(posedge clock);
    #1 drive(0, 1'b1, 1'b1, 16'h0020, 16'h0000);
    ncomp = 0;
    first = 0;
    bok = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      if (cmp0 === 1'b1) begin
        ncomp++;
        if (first == 0) first = i;
      end
      if (i <= 3 && busy0 !== 1'b1) bok = 1'b0;
      if (i == 1) begin
        @(posedge clock);
        #1 drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
    end
    check("ign_count", 32'(ncomp), 32'd1);
    check("ign_lat", 32'(first), 32'd3);
    check("ign_busy", 32'(bok), 32'd1);
    check("ign_dout", 32'(dout0), 32'(vecs[13].exp_dout));
    txn(0, 1'b1, 16'h0020, 16'h0000, lat, dv, ev, bok);
    check("ign_rd_lat", 32'(lat), 32'd3);
    check("ign_rd_dout", 32'(dv), 32'hCAFE);

    // Zero-wait instance, back-to-back requests.
    txn(1, 1'b0, 16'h0005, 16'h1357, lat, dv, ev, bok);
    check("w0_wr_lat", 32'(lat), 32'd1);
    check("w0_wr_dout", 32'(dv), 32'h0);
    txn(1, 1'b1, 16'h0005, 16'h0000, lat, dv, ev, bok);
    check("w0_rd_lat", 32'(lat), 32'd1);
    check("w0_rd_dout", 32'(dv), 32'h1357);
    txn(1, 1'b0, 16'h0005, 16'h2468, lat, dv, ev, bok);
    check("w0_b2b_wr_lat", 32'(lat), 32'd1);
    txn(1, 1'b1, 16'h0005, 16'h0000, lat, dv, ev, bok);
    check("w0_b2b_rd_lat", 32'(lat), 32'd1);
    check("w0_b2b_rd_dout", 32'(dv), 32'h2468);

    // Reset during WAIT aborts the write.
    txn(0, 1'b0, 16'h0030, 16'h0BAD, lat, dv, ev, bok);
    check("mid_pre_lat", 32'(lat), 32'd3);
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 16'h0030, 16'hBEEF);
    @(posedge clock);
    #1 drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(negedge clock);
    check("mid_state_wait", 32'(st0), 32'h1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_cmp", 32'(cmp0), 32'h0);
    check("mid_rst_busy", 32'(busy0), 32'h0);
    check("mid_rst_dout", 32'(dout0), 32'h0);
    check("mid_rst_state", 32'(st0), 32'h0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    ncomp = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (cmp0 === 1'b1) ncomp++;
    end
    check("mid_no_cmp", 32'(ncomp), 32'd0);
    txn(0, 1'b1, 16'h0030, 16'h0000, lat, dv, ev, bok);
    check("mid_rd_lat", 32'(lat), 32'd3);
    check("mid_rd_dout", 32'(dv), 32'h0BAD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
